// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the packet-buffer free list: block
//               index width, default block count and the free-list FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Width of a buffer block index.
  localparam int ADDR_W         = 3;
  // Default number of managed blocks (full index space).
  localparam int NUM_BLOCKS_DEF = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/fl_ram.sv
`default_nettype none
// ============================================================================
// Module      : fl_ram
// Description : DEPTH x DW flop array holding the free-list FIFO entries.
//               One synchronous write port, one combinational read port.
//               Contents are intentionally not reset; the free list
//               initialises them itself after reset.
// Ports       : clk    - system clock
//               we     - write enable
//               waddr  - write address
//               wdata  - write data
//               raddr  - read address
//               rdata  - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module fl_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fl_ram
`default_nettype wire

// File: rtl/mem_free_list.sv
`default_nettype none
// ============================================================================
// Module      : mem_free_list
// Description : Free-block list for the shared packet buffer. After reset it
//               loads every block index 0..NUM_BLOCKS-1 into a circular FIFO,
//               then hands out one index per cycle on alloc (same-cycle
//               grant) and accepts released indices on free, in strict FIFO
//               order.
// Ports       : clk                  - system clock
//               rst_n                - asynchronous active-low reset
//               fl_alloc_req_i       - alloc request (level)
//               fl_alloc_gnt_o       - alloc granted this cycle (comb)
//               fl_alloc_block_idx_o - block index at FIFO head (0 if empty)
//               fl_free_req_i        - single-cycle free pulse
//               fl_free_block_idx_i  - index being returned
//               fl_ready_o           - init finished, list in service
//               fl_free_count_o      - number of free blocks held
//               fl_err_o             - sticky illegal-free flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_free_list
  import mem_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fl_alloc_req_i,
  output logic                            fl_alloc_gnt_o,
  output logic [ADDR_W-1:0]               fl_alloc_block_idx_o,
  input  logic                            fl_free_req_i,
  input  logic [ADDR_W-1:0]               fl_free_block_idx_i,
  output logic                            fl_ready_o,
  output logic [$clog2(NUM_BLOCKS+1)-1:0] fl_free_count_o,
  output logic                            fl_err_o
);

  localparam int PTR_W = $clog2(NUM_BLOCKS);
  localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

  fl_state_t          state;
  logic [PTR_W-1:0]   init_cnt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               err;

  logic               not_empty;
  logic               full;
  logic               alloc_fire;
  logic               free_fire;
  logic               ram_we;
  logic [PTR_W-1:0]   ram_waddr;
  logic [ADDR_W-1:0]  ram_wdata;
  logic [ADDR_W-1:0]  ram_rdata;

  // count is held at 0 for the whole of INIT, so not_empty alone keeps the
  // grant and the index output quiet until the list is in service.
  assign not_empty  = (count != CNT_W'(0));
  assign full       = (count == CNT_W'(NUM_BLOCKS));
  assign alloc_fire = (state == FL_RUN) && fl_alloc_req_i && not_empty;
  assign free_fire  = (state == FL_RUN) && fl_free_req_i && !full;

  // During INIT the write port is owned by the init walker; afterwards it
  // takes returned indices. There is no empty bypass: a freed index is only
  // visible at the head one cycle after it is written.
  always_comb begin
    ram_we    = free_fire;
    ram_waddr = wr_ptr;
    ram_wdata = fl_free_block_idx_i;
    if (state == FL_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt;
      ram_wdata = ADDR_W'(init_cnt);
    end
  end

  fl_ram #(
    .DEPTH (NUM_BLOCKS),
    .AW    (PTR_W),
    .DW    (ADDR_W)
  ) u_fl_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FL_INIT;
      init_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        FL_INIT: begin
          init_cnt <= init_cnt + PTR_W'(1);
          // Frees cannot be honoured before the list exists.
          if (fl_free_req_i) begin
            err <= 1'b1;
          end
          if (init_cnt == PTR_W'(NUM_BLOCKS - 1)) begin
            state  <= FL_RUN;
            count  <= CNT_W'(NUM_BLOCKS);
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        FL_RUN: begin
          if (alloc_fire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
          if (free_fire) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          // A free while full can only be a duplicate release.
          if (fl_free_req_i && full) begin
            err <= 1'b1;
          end
          if (alloc_fire && !free_fire) begin
            count <= count - CNT_W'(1);
          end else if (free_fire && !alloc_fire) begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= FL_INIT;
      endcase
    end
  end

  assign fl_alloc_gnt_o       = alloc_fire;
  assign fl_alloc_block_idx_o = not_empty ? ram_rdata : '0;
  assign fl_ready_o           = (state == FL_RUN);
  assign fl_free_count_o      = count;
  assign fl_err_o             = err;

endmodule : mem_free_list
`default_nettype wire

// File: tb/tb_mem_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_free_list
// Description : Self-checking bench for mem_free_list (NUM_BLOCKS=8,
//               ADDR_W=3). A vector table drives alloc/free each cycle and
//               holds the expected outputs sampled just before the next
//               rising edge; hand-written sequences cover asynchronous reset
//               in the middle of service.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_free_list;
  import mem_pkg::*;

  localparam int NB    = 8;
  localparam int CNT_W = $clog2(NB + 1);

  logic              clk;
  logic              rst_n;
  logic              alloc_req;
  logic              alloc_gnt;
  logic [ADDR_W-1:0] alloc_idx;
  logic              free_req;
  logic [ADDR_W-1:0] free_idx;
  logic              ready;
  logic [CNT_W-1:0]  free_count;
  logic              err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       req;
    logic       fr;
    logic [2:0] fi;
    logic       gnt;
    logic [2:0] idx;
    logic       rdy;
    int         cnt;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  mem_free_list #(.NUM_BLOCKS(NB)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fl_alloc_req_i       (alloc_req),
    .fl_alloc_gnt_o       (alloc_gnt),
    .fl_alloc_block_idx_o (alloc_idx),
    .fl_free_req_i        (free_req),
    .fl_free_block_idx_i  (free_idx),
    .fl_ready_o           (ready),
    .fl_free_count_o      (free_count),
    .fl_err_o             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic fr, input int fi,
                     input logic gnt, input int idx, input logic rdy,
                     input int cnt, input logic er);
    vec_t v;
    v.req = req; v.fr = fr; v.fi = 3'(fi);
    v.gnt = gnt; v.idx = 3'(idx); v.rdy = rdy; v.cnt = cnt; v.er = er;
    vecs.push_back(v);
  endtask

  // Entered at posedge+1: drive, let combinational outputs settle, compare
  // just before the next edge, then step to the next posedge+1.
  task automatic apply(input vec_t v, input int n);
    alloc_req = v.req;
    free_req  = v.fr;
    free_idx  = v.fi;
    #4;
    chk("gnt",   n, 32'(alloc_gnt),  32'(v.gnt));
    chk("idx",   n, 32'(alloc_idx),  32'(v.idx));
    chk("ready", n, 32'(ready),      32'(v.rdy));
    chk("count", n, 32'(free_count), 32'(v.cnt));
    chk("err",   n, 32'(err),        32'(v.er));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    free_req  = 1'b0;
    free_idx  = '0;

    // ---------------- phase A table ----------------
    // INIT: 8 cycles, request held, no grant.
    for (int k = 0; k < NB; k++) add(1, 0, 0, 0, 0, 0, 0, 0);
    // Initial contents come out 0..7.
    for (int k = 0; k < NB; k++) add(1, 0, 0, 1, k, 1, NB - k, 0);
    // Empty: no grant, index forced to 0.
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    // Empty with free and request together: no bypass.
    add(1, 1, 5, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 5, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // FIFO order: free 3,6,1 then alloc 3,6,1.
    add(0, 1, 3, 0, 0, 1, 0, 0);
    add(0, 1, 6, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 2, 0);
    add(1, 0, 0, 1, 3, 1, 3, 0);
    add(1, 0, 0, 1, 6, 1, 2, 0);
    add(1, 0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    // Simultaneous alloc and free at count=1 (head=2).
    add(0, 1, 2, 0, 0, 1, 0, 0);
    add(1, 1, 7, 1, 2, 1, 1, 0);
    add(1, 0, 0, 1, 7, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // Refill with 0..7 (head stays 0 once written).
    for (int k = 0; k < NB; k++) add(0, 1, k, 0, 0, 1, k, 0);
    // Free while full: dropped, err goes sticky next cycle.
    add(0, 1, 4, 0, 0, 1, NB, 0);
    add(0, 0, 0, 0, 0, 1, NB, 1);
    // Order unchanged by the dropped free.
    for (int k = 0; k < NB; k++) add(1, 0, 0, 1, k, 1, NB - k, 1);
    add(1, 0, 0, 0, 0, 1, 0, 1);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",   0, 32'(alloc_gnt),  32'd0);
    chk("rst_idx",   0, 32'(alloc_idx),  32'd0);
    chk("rst_ready", 0, 32'(ready),      32'd0);
    chk("rst_count", 0, 32'(free_count), 32'd0);
    chk("rst_err",   0, 32'(err),        32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // ---------------- reset mid-RUN ----------------
    begin
      vec_t v;
      int   n;
      n = 1000;
      // Bring count to 4 with head=4.
      for (int k = 0; k < 4; k++) begin
        v.req = 0; v.fr = 1; v.fi = 3'(4 + k);
        v.gnt = 0; v.idx = (k == 0) ? 3'd0 : 3'd4;
        v.rdy = 1; v.cnt = k; v.er = 1;
        apply(v, n++);
      end
      alloc_req = 1'b1;
      free_req  = 1'b0;
      #2;
      chk("pre_gnt",   n, 32'(alloc_gnt),  32'd1);
      chk("pre_count", n, 32'(free_count), 32'd4);
      rst_n = 1'b0;
      #1;
      chk("arst_gnt",   n, 32'(alloc_gnt),  32'd0);
      chk("arst_ready", n, 32'(ready),      32'd0);
      chk("arst_count", n, 32'(free_count), 32'd0);
      chk("arst_err",   n, 32'(err),        32'd0);
      chk("arst_idx",   n, 32'(alloc_idx),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 2000;
      // INIT again; a free in the first INIT cycle is flagged.
      for (int k = 0; k < NB; k++) begin
        v.req = 1; v.fr = (k == 0); v.fi = 3'd3;
        v.gnt = 0; v.idx = 3'd0; v.rdy = 0; v.cnt = 0; v.er = (k != 0);
        apply(v, n++);
      end
      // Dropped INIT free leaves count at 8; allocs return 0..7.
      for (int k = 0; k < NB; k++) begin
        v.req = 1; v.fr = 0; v.fi = 3'd0;
        v.gnt = 1; v.idx = 3'(k); v.rdy = 1; v.cnt = NB - k; v.er = 1;
        apply(v, n++);
      end
      v.req = 1; v.fr = 0; v.fi = 3'd0;
      v.gnt = 0; v.idx = 3'd0; v.rdy = 1; v.cnt = 0; v.er = 1;
      apply(v, n++);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_free_list
`default_nettype wire

// File: doc/mem_free_list.md
Name: mem_free_list

Overview:
- Free-block list for the shared packet buffer; sits directly downstream of the round-robin free-list allocation arbiter.
- Hands out one free block index per cycle to the arbiter's alloc request.
- Takes back released block indices from the memory read side.
- On reset, walks an init sequence that loads every block index, then serves alloc/free in FIFO order.

Parameters:
- NUM_BLOCKS, default 2**ADDR_W (from mem_pkg): number of buffer blocks managed; must be a power of two and at most 2**ADDR_W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- fl_alloc_req_i  input  1  alloc request from arbiter, level, may change every cycle
- fl_alloc_gnt_o  output  1  alloc granted this cycle (combinational)
- fl_alloc_block_idx_o  output  ADDR_W  block index handed out; valid when gnt=1
- fl_free_req_i  input  1  single-cycle pulse: return one block
- fl_free_block_idx_i  input  ADDR_W  index being returned
- fl_ready_o  output  1  init complete, list in service
- fl_free_count_o  output  $clog2(NUM_BLOCKS+1)  current number of free blocks
- fl_err_o  output  1  sticky: illegal free (during INIT or when full)

Behaviour:
- Reset values:
  - state=INIT, init_cnt=0, rd_ptr=0, wr_ptr=0, count=0.
  - fl_ready_o=0, fl_err_o=0, fl_alloc_gnt_o=0, fl_alloc_block_idx_o=0.
  - Storage contents are not reset.
- State machine (fl_state_t): INIT -> RUN. There is no other transition; only rst_n re-enters INIT.
- INIT:
  - Each cycle writes storage[init_cnt]=init_cnt, then init_cnt++.
  - On the cycle writing NUM_BLOCKS-1: next state RUN, count<=NUM_BLOCKS, wr_ptr<=0 (wrapped), rd_ptr<=0.
  - INIT lasts exactly NUM_BLOCKS cycles after reset deassertion; fl_ready_o=1 from the first RUN cycle.
  - fl_alloc_gnt_o=0 throughout INIT.
  - fl_free_req_i during INIT is dropped and sets fl_err_o.
- RUN, alloc:
  - fl_alloc_gnt_o = fl_alloc_req_i && (count!=0), combinational, same cycle, so the arbiter can route it to its current requester.
  - fl_alloc_block_idx_o = storage[rd_ptr] whenever count!=0, else 0.
  - On gnt: rd_ptr++ (mod NUM_BLOCKS), count--.
- RUN, free:
  - On fl_free_req_i with count<NUM_BLOCKS: storage[wr_ptr]=fl_free_block_idx_i, wr_ptr++ (mod NUM_BLOCKS), count++.
  - Free with count==NUM_BLOCKS: dropped, fl_err_o<=1, no pointer or count change.
- Simultaneous alloc gnt and free in one cycle: both take effect; count unchanged.
- Empty with free pulse and alloc request in the same cycle:
  - gnt=0; there is no bypass.
  - The freed index is written, and a gnt can follow next cycle.
- Ordering: strict FIFO. After init, indices come out 0,1,…,NUM_BLOCKS-1, then in the order they were freed.
- Arithmetic: pointers are $clog2(NUM_BLOCKS) bits and wrap naturally. count never exceeds NUM_BLOCKS or underflows below 0.
- No duplicate-index detection; the double-free check is limited to the overflow case.
- fl_err_o clears only on reset.
- Reset mid-operation: all state returns to INIT asynchronously; the same cycle drops gnt and ready; in-flight frees are lost.
- Latency: alloc 0 cycles (same-cycle gnt). A freed index becomes allocatable 1 cycle later, or later if it sits behind others in the FIFO.

Decomposition:
- mem_pkg: ADDR_W, NUM_BLOCKS default, fl_state_t enum {FL_INIT, FL_RUN}.
- Sub-module fl_ram: NUM_BLOCKS x ADDR_W flop array, one write port and one combinational read port, no reset.
- All pointer, count and FSM logic lives in mem_free_list.

Test Plan:
- Init (NUM_BLOCKS=8, ADDR_W=3): release rst_n, hold fl_alloc_req_i=1 -> gnt=0 for 8 cycles, ready=1 on cycle 9, then gnt each cycle with idx 0,1,…,7, count 8→0.
- Empty: after 8 allocs, req held -> gnt=0, idx=0, count=0. Free idx 5 -> next cycle gnt=1, idx=5.
- FIFO order: from empty, free 3, 6, 1 on consecutive cycles -> allocs return 3, 6, 1; count 3→0.
- Simultaneous: count=1 (head=2), alloc req plus free idx 7 in the same cycle -> gnt=1, idx=2, count stays 1; next alloc returns 7.
- Errors: free during INIT -> fl_err_o=1, count unaffected at RUN (8). Separately, free at count=8 -> err=1, count=8, order unchanged.
- Reset mid-RUN: count=4, assert rst_n=0 -> gnt/ready/count/err=0 immediately. Release -> 8-cycle INIT, then allocs return 0..7.
